mux_4_arb: RTL and testbench

MUX_4_ARB -- requirements
Module: mux_4_arb

---
 rtl/mux_4_arb_if.sv | 27 ++
 rtl/mux_4_arb.sv | 103 ++++++++++
 tb/tb_mux_4_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_arb_if.sv
// Bundle of request, data and handshake signals between four requesters,
// the round-robin capture mux and its downstream consumer.
interface mux_4_arb_if #(
  parameter int W = 4
);
  logic [3:0]   req;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] z;
  logic [W-1:0] w;
  logic         q_ready;
  logic [W-1:0] q;
  logic         q_valid;
  logic [1:0]   sel;
  logic [3:0]   ack;
  logic         busy;

  modport master (
    output req, x, y, z, w, q_ready,
    input  q, q_valid, sel, ack, busy
  );

  modport slave (
    input  req, x, y, z, w, q_ready,
    output q, q_valid, sel, ack, busy
  );
endinterface

// File: rtl/mux_4_arb.sv
// Four-way round-robin arbiter that captures the winning requester's word
// into a registered output and holds it until the consumer takes it.
module mux_4_arb #(
  parameter int W = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_4_arb_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       state, state_nx;
  logic [1:0]   ptr;
  logic [1:0]   winner;
  logic         load;
  logic         done;
  logic [W-1:0] q_p1;
  logic [1:0]   sel_p1;
  logic [3:0]   ack_p1;
  logic         vld_p1;

  // Search ptr+1 .. ptr+4; scanning farthest-first lets the nearest set bit win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i) + 2'd1;
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [W-1:0] word_of(input logic [1:0] s,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c,
                                           input logic [W-1:0] d);
    case (s)
      2'd0:    word_of = a;
      2'd1:    word_of = b;
      2'd2:    word_of = c;
      default: word_of = d;
    endcase
  endfunction

  assign winner = rr_pick(bus.req, ptr);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          load     = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        // q_valid is high for the whole of SEND, so q_ready alone completes it.
        if (bus.q_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Stage p1: captured word, grant index and one-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p1   <= '0;
      sel_p1 <= 2'd0;
      ack_p1 <= 4'd0;
      ptr    <= 2'd3;
    end else begin
      ack_p1 <= 4'd0;
      if (load) begin
        q_p1   <= word_of(winner, bus.x, bus.y, bus.z, bus.w);
        sel_p1 <= winner;
        ack_p1 <= 4'd1 << winner;
      end
      if (done) ptr <= sel_p1;
    end
  end

  assign vld_p1      = (state == SEND);
  assign bus.q       = q_p1;
  assign bus.sel     = sel_p1;
  assign bus.ack     = ack_p1;
  assign bus.q_valid = vld_p1;
  assign bus.busy    = vld_p1;

endmodule

// File: tb/tb_mux_4_arb.sv
// Directed bench for mux_4_arb: stimulus queues expected grants, a negedge
// monitor checks every acknowledged capture against the queue.
module tb_mux_4_arb;

  logic clk;
  logic rst_n;

  mux_4_arb_if #(.W(4)) bus ();

  mux_4_arb #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] q, input logic [1:0] s);
    exp_t e;
    e.q   = q;
    e.sel = s;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Monitor: every acknowledged capture must match the next queued grant.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ack != 4'd0) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("mon_q",       32'(bus.q),       32'(e.q));
        check("mon_sel",     32'(bus.sel),     32'(e.sel));
        check("mon_ack",     32'(bus.ack),     32'(4'd1 << e.sel));
        check("mon_q_valid", 32'(bus.q_valid), 32'd1);
      end
    end
  end

  initial begin
    logic [3:0] ack_seq [5];
    ack_seq[0] = 4'b0001;
    ack_seq[1] = 4'b0010;
    ack_seq[2] = 4'b0100;
    ack_seq[3] = 4'b1000;
    ack_seq[4] = 4'b0001;

    rst_n       = 1'b0;
    bus.req     = 4'd0;
    bus.x       = 4'd3;
    bus.y       = 4'd4;
    bus.z       = 4'd8;
    bus.w       = 4'd2;
    bus.q_ready = 1'b0;

    // Reset values before any clock edge.
    #3;
    check("rst_q",       32'(bus.q),       32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_ack",     32'(bus.ack),     32'd0);
    check("rst_sel",     32'(bus.sel),     32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    tick;
    rst_n = 1'b1;

    // No request for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick;
      check("idle_quiet", 32'({bus.q_valid, bus.ack, bus.busy}), 32'd0);
    end

    // Single request from x.
    bus.q_ready = 1'b1;
    bus.req     = 4'b0001;
    push(4'd3, 2'd0);
    tick;
    check("single_ack",  32'(bus.ack),     32'b0001);
    check("single_vld",  32'(bus.q_valid), 32'd1);
    bus.req = 4'd0;
    tick;
    check("single_done_vld",  32'(bus.q_valid), 32'd0);
    check("single_done_busy", 32'(bus.busy),    32'd0);
    check("single_q_retain",  32'(bus.q),       32'd3);

    // Full contention from a fresh reset: x, y, z, w, x, one word per 2 cycles.
    do_reset;
    bus.q_ready = 1'b1;
    push(4'd3, 2'd0);
    push(4'd4, 2'd1);
    push(4'd8, 2'd2);
    push(4'd2, 2'd3);
    push(4'd3, 2'd0);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("cont_ack",  32'(bus.ack),  32'(ack_seq[k]));
      check("cont_busy", 32'(bus.busy), 32'd1);
      if (k == 4) bus.req = 4'd0;
      tick;
      check("cont_bubble", 32'({bus.busy, bus.ack}), 32'd0);
    end

    // Fairness: serve y so ptr=1, then x wins over y.
    bus.req = 4'b0010;
    push(4'd4, 2'd1);
    tick;
    check("fair_pre_ack", 32'(bus.ack), 32'b0010);
    bus.req = 4'd0;
    tick;
    bus.req = 4'b0011;
    push(4'd3, 2'd0);
    push(4'd4, 2'd1);
    tick;
    check("fair_x_ack", 32'(bus.ack), 32'b0001);
    check("fair_x_q",   32'(bus.q),   32'd3);
    bus.req = 4'b0010;
    tick;
    tick;
    check("fair_y_ack", 32'(bus.ack), 32'b0010);
    bus.req = 4'd0;
    tick;

    // Backpressure: z held for 10 cycles with q_ready low.
    bus.q_ready = 1'b0;
    bus.req     = 4'b0100;
    push(4'd8, 2'd2);
    tick;
    check("bp_ack", 32'(bus.ack), 32'b0100);
    bus.req = 4'd0;
    for (int i = 0; i < 9; i++) begin
      tick;
      check("bp_hold", 32'({bus.q, bus.sel, bus.q_valid, bus.ack}),
            32'({4'd8, 2'd2, 1'b1, 4'd0}));
    end
    bus.q_ready = 1'b1;
    tick;
    check("bp_done_vld", 32'(bus.q_valid), 32'd0);
    check("bp_q_retain", 32'(bus.q),       32'd8);
    tick;
    check("bp_no_reack", 32'(bus.ack), 32'd0);

    // Reset during SEND discards w's word; w is regranted after release.
    bus.q_ready = 1'b0;
    bus.req     = 4'b1000;
    push(4'd2, 2'd3);
    tick;
    check("rsend_ack", 32'(bus.ack), 32'b1000);
    check("rsend_q",   32'(bus.q),   32'd2);
    bus.req = 4'd0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("rsend_async_q",    32'(bus.q),       32'd0);
    check("rsend_async_vld",  32'(bus.q_valid), 32'd0);
    check("rsend_async_busy", 32'(bus.busy),    32'd0);
    #1;
    rst_n = 1'b1;
    tick;
    check("rsend_no_reack", 32'({bus.ack, bus.q_valid}), 32'd0);
    bus.req = 4'b1000;
    push(4'd2, 2'd3);
    tick;
    check("rsend_regrant_ack", 32'(bus.ack), 32'b1000);
    check("rsend_regrant_sel", 32'(bus.sel), 32'd3);
    bus.req     = 4'd0;
    bus.q_ready = 1'b1;
    tick;
    check("rsend_regrant_done", 32'(bus.q_valid), 32'd0);

    repeat (3) tick;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
